// File: rtl/pipelined_cpu.sv
// Five-stage MIPS-subset pipeline (IF, ID, EX, MEM, WB) with EX forwarding,
// load-use and branch-operand stalls, and branch/jump resolution in ID.
module pipelined_cpu (
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_t;
  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    alu_op_t alu_op;
  } ctrl_t;

  logic [31:0] imem [0:255];
  logic [7:0]  dmem [0:31];
  logic [31:0] rf   [0:31];

  logic [31:0] pc_reg;
  logic [31:0] ifid_instr_reg, ifid_pc_reg;
  ctrl_t       idex_ctrl_reg;
  logic [4:0]  idex_rs_reg, idex_rt_reg, idex_dst_reg;
  logic [31:0] idex_a_reg, idex_b_reg, idex_imm_reg;
  ctrl_t       exmem_ctrl_reg;
  logic [4:0]  exmem_dst_reg;
  logic [31:0] exmem_alu_reg, exmem_store_reg;
  logic        memwb_reg_write_reg;
  logic [4:0]  memwb_dst_reg;
  logic [31:0] memwb_data_reg;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, id_dst;
  logic [31:0] imm_sext;
  ctrl_t       id_ctrl;
  logic        is_beq, is_j;

  assign opcode   = ifid_instr_reg[31:26];
  assign rs       = ifid_instr_reg[25:21];
  assign rt       = ifid_instr_reg[20:16];
  assign rd       = ifid_instr_reg[15:11];
  assign funct    = ifid_instr_reg[5:0];
  assign imm_sext = {{16{ifid_instr_reg[15]}}, ifid_instr_reg[15:0]};

  // Anything not decoded here leaves every control bit at 0, i.e. a NOP.
  always_comb begin
    id_ctrl = '0;
    id_dst  = rt;
    is_beq  = 1'b0;
    is_j    = 1'b0;
    case (opcode)
      6'b000000: begin
        id_dst = rd;
        id_ctrl.reg_write = 1'b1;
        case (funct)
          6'b100000: id_ctrl.alu_op = ALU_ADD;
          6'b100010: id_ctrl.alu_op = ALU_SUB;
          6'b100100: id_ctrl.alu_op = ALU_AND;
          6'b100101: id_ctrl.alu_op = ALU_OR;
          6'b011000: id_ctrl.alu_op = ALU_MUL;
          default:   id_ctrl.reg_write = 1'b0;
        endcase
      end
      6'b001000: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
      end
      6'b100011: begin
        id_ctrl.reg_write  = 1'b1;
        id_ctrl.mem_read   = 1'b1;
        id_ctrl.mem_to_reg = 1'b1;
        id_ctrl.alu_src    = 1'b1;
      end
      6'b101011: begin
        id_ctrl.mem_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
      end
      6'b000100: is_beq = 1'b1;
      6'b000010: is_j   = 1'b1;
      default: ;
    endcase
  end

  // Register read with write-before-read bypass from WB.
  logic        wb_fire;
  logic [31:0] rs_val, rt_val, br_a, br_b;
  assign wb_fire = memwb_reg_write_reg && (memwb_dst_reg != 5'd0);
  assign rs_val  = (rs == 5'd0) ? 32'd0 : (wb_fire && memwb_dst_reg == rs) ? memwb_data_reg : rf[rs];
  assign rt_val  = (rt == 5'd0) ? 32'd0 : (wb_fire && memwb_dst_reg == rt) ? memwb_data_reg : rf[rt];

  logic exmem_fwd_rs, exmem_fwd_rt;
  assign exmem_fwd_rs = exmem_ctrl_reg.reg_write && (exmem_dst_reg != 5'd0) && (exmem_dst_reg == rs);
  assign exmem_fwd_rt = exmem_ctrl_reg.reg_write && (exmem_dst_reg != 5'd0) && (exmem_dst_reg == rt);
  assign br_a = exmem_fwd_rs ? exmem_alu_reg : rs_val;
  assign br_b = exmem_fwd_rt ? exmem_alu_reg : rt_val;

  // A beq cannot see results still in EX, nor load data before it leaves MEM.
  logic load_use, ex_dep, mem_load_dep, stall, redirect;
  logic [31:0] pc_plus4_id, redirect_pc;
  assign load_use     = idex_ctrl_reg.mem_read && (idex_dst_reg == rs || idex_dst_reg == rt);
  assign ex_dep       = idex_ctrl_reg.reg_write && (idex_dst_reg != 5'd0) &&
                        (idex_dst_reg == rs || idex_dst_reg == rt);
  assign mem_load_dep = exmem_ctrl_reg.mem_read && (exmem_dst_reg != 5'd0) &&
                        (exmem_dst_reg == rs || exmem_dst_reg == rt);
  assign stall        = load_use || (is_beq && (ex_dep || mem_load_dep));
  assign redirect     = !stall && (is_j || (is_beq && br_a == br_b));
  assign pc_plus4_id  = ifid_pc_reg + 32'd4;
  assign redirect_pc  = is_j ? {pc_plus4_id[31:28], ifid_instr_reg[25:0], 2'b00}
                             : pc_plus4_id + {imm_sext[29:0], 2'b00};

  // EX: EX/MEM forwarding wins over MEM/WB.
  logic [31:0] fwd_a, fwd_b, op_b, alu_res;
  always_comb begin
    fwd_a = idex_a_reg;
    fwd_b = idex_b_reg;
    if (exmem_ctrl_reg.reg_write && exmem_dst_reg != 5'd0 && exmem_dst_reg == idex_rs_reg)
      fwd_a = exmem_alu_reg;
    else if (wb_fire && memwb_dst_reg == idex_rs_reg)
      fwd_a = memwb_data_reg;
    if (exmem_ctrl_reg.reg_write && exmem_dst_reg != 5'd0 && exmem_dst_reg == idex_rt_reg)
      fwd_b = exmem_alu_reg;
    else if (wb_fire && memwb_dst_reg == idex_rt_reg)
      fwd_b = memwb_data_reg;
    op_b = idex_ctrl_reg.alu_src ? idex_imm_reg : fwd_b;
    case (idex_ctrl_reg.alu_op)
      ALU_SUB: alu_res = fwd_a - op_b;
      ALU_AND: alu_res = fwd_a & op_b;
      ALU_OR:  alu_res = fwd_a | op_b;
      ALU_MUL: alu_res = fwd_a * op_b;
      default: alu_res = fwd_a + op_b;
    endcase
  end

  logic [31:0] load_word;
  for (genvar gi = 0; gi < 4; gi++) begin : g_load_lane
    assign load_word[8*gi +: 8] = dmem[{exmem_alu_reg[4:2], 2'(gi)}];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_reg              <= '0;
      ifid_instr_reg      <= '0;
      ifid_pc_reg         <= '0;
      idex_ctrl_reg       <= '0;
      idex_rs_reg         <= '0;
      idex_rt_reg         <= '0;
      idex_dst_reg        <= '0;
      idex_a_reg          <= '0;
      idex_b_reg          <= '0;
      idex_imm_reg        <= '0;
      exmem_ctrl_reg      <= '0;
      exmem_dst_reg       <= '0;
      exmem_alu_reg       <= '0;
      exmem_store_reg     <= '0;
      memwb_reg_write_reg <= 1'b0;
      memwb_dst_reg       <= '0;
      memwb_data_reg      <= '0;
    end else if (start_i) begin
      if (!stall) begin
        pc_reg <= redirect ? redirect_pc : pc_reg + 32'd4;
        if (redirect) begin
          ifid_instr_reg <= '0;
          ifid_pc_reg    <= '0;
        end else begin
          ifid_instr_reg <= imem[pc_reg[9:2]];
          ifid_pc_reg    <= pc_reg;
        end
      end
      idex_ctrl_reg       <= stall ? '0 : id_ctrl;
      idex_rs_reg         <= stall ? 5'd0 : rs;
      idex_rt_reg         <= stall ? 5'd0 : rt;
      idex_dst_reg        <= stall ? 5'd0 : id_dst;
      idex_a_reg          <= stall ? 32'd0 : rs_val;
      idex_b_reg          <= stall ? 32'd0 : rt_val;
      idex_imm_reg        <= stall ? 32'd0 : imm_sext;
      exmem_ctrl_reg      <= idex_ctrl_reg;
      exmem_dst_reg       <= idex_dst_reg;
      exmem_alu_reg       <= alu_res;
      exmem_store_reg     <= fwd_b;
      memwb_reg_write_reg <= exmem_ctrl_reg.reg_write;
      memwb_dst_reg       <= exmem_dst_reg;
      memwb_data_reg      <= exmem_ctrl_reg.mem_to_reg ? load_word : exmem_alu_reg;
    end
  end

  // Architectural state is never reset; writes are suppressed on reset edges.
  always_ff @(posedge clk_i) begin
    if (!rst_i && start_i) begin
      if (wb_fire)
        rf[memwb_dst_reg] <= memwb_data_reg;
      if (exmem_ctrl_reg.mem_write)
        for (int k = 0; k < 4; k++)
          dmem[{exmem_alu_reg[4:2], 2'(k)}] <= exmem_store_reg[8*k +: 8];
    end
  end
endmodule

// File: tb/tb_pipelined_cpu.sv
// Directed scenarios plus random programs checked against an instruction-level
// interpreter of the same MIPS subset.
module tb_pipelined_cpu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int checks = 0;
  int failures = 0;

  logic [31:0] prog [0:63];
  logic [31:0] m_rf [0:31];
  logic [7:0]  m_dm [0:31];

  always #5 clk = ~clk;

  pipelined_cpu dut (.clk_i(clk), .rst_i(rst), .start_i(start));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] f, input int s, input int t, input int d);
    return {6'b000000, 5'(s), 5'(t), 5'(d), 5'd0, f};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int s, input int t, input int imm);
    return {op, 5'(s), 5'(t), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_ins(input int w);
    return {6'b000010, 26'(w)};
  endfunction

  task automatic hold_reset();
    rst = 1'b1;
    start = 1'b0;
    tick(2);
  endtask

  task automatic go();
    rst = 1'b0;
    start = 1'b1;
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < 256; i++) begin
      if (i < n) dut.imem[i] = prog[i];
      else       dut.imem[i] = 32'd0;
    end
  endtask

  task automatic m_write(input logic [4:0] d, input logic [31:0] v);
    if (d != 5'd0) m_rf[d] = v;
  endtask

  // Executes the program one instruction at a time, in program order.
  task automatic run_model(input int n);
    logic [31:0] pc, npc, ins, a, b, imm;
    logic [4:0] adr;
    int steps;
    pc = 32'd0;
    steps = 0;
    while (pc < 32'(4 * n) && steps < 1000) begin
      ins = prog[pc[7:2]];
      npc = pc + 32'd4;
      a = m_rf[ins[25:21]];
      b = m_rf[ins[20:16]];
      imm = {{16{ins[15]}}, ins[15:0]};
      adr = 5'(a + imm) & 5'b11100;
      case (ins[31:26])
        6'b000000: begin
          case (ins[5:0])
            6'b100000: m_write(ins[15:11], a + b);
            6'b100010: m_write(ins[15:11], a - b);
            6'b100100: m_write(ins[15:11], a & b);
            6'b100101: m_write(ins[15:11], a | b);
            6'b011000: m_write(ins[15:11], a * b);
            default: ;
          endcase
        end
        6'b001000: m_write(ins[20:16], a + imm);
        6'b100011: m_write(ins[20:16], {m_dm[adr + 5'd3], m_dm[adr + 5'd2], m_dm[adr + 5'd1], m_dm[adr]});
        6'b101011: begin
          m_dm[adr]        = b[7:0];
          m_dm[adr + 5'd1] = b[15:8];
          m_dm[adr + 5'd2] = b[23:16];
          m_dm[adr + 5'd3] = b[31:24];
        end
        6'b000100: if (a == b) npc = pc + 32'd4 + (imm << 2);
        6'b000010: npc = {npc[31:28], ins[25:0], 2'b00};
        default: ;
      endcase
      pc = npc;
      steps++;
    end
  endtask

  // Branches and jumps only go forward so every program runs off its end.
  task automatic gen_prog(input int n);
    for (int i = 0; i < n; i++) begin
      int k, s, t, d, tw;
      k  = $urandom_range(0, 11);
      s  = $urandom_range(0, 7);
      t  = $urandom_range(0, 7);
      d  = $urandom_range(0, 7);
      tw = $urandom_range(i + 1, n);
      case (k)
        0: prog[i] = r_ins(6'b100000, s, t, d);
        1: prog[i] = r_ins(6'b100010, s, t, d);
        2: prog[i] = r_ins(6'b100100, s, t, d);
        3: prog[i] = r_ins(6'b100101, s, t, d);
        4: prog[i] = r_ins(6'b011000, s, t, d);
        5: prog[i] = i_ins(6'b001000, s, t, $urandom_range(0, 65535));
        6: prog[i] = i_ins(6'b100011, s, t, int'($urandom_range(0, 63)) - 32);
        7: prog[i] = i_ins(6'b101011, s, t, int'($urandom_range(0, 63)) - 32);
        8: prog[i] = i_ins(6'b000100, s, t, tw - (i + 1));
        9: prog[i] = j_ins(tw);
        10: prog[i] = r_ins(6'b000001, s, t, d);
        default: prog[i] = {6'b111111, 26'($urandom)};
      endcase
    end
  endtask

  initial begin
    // Scenario: back-to-back addi, EX/MEM forwarding, five-cycle latency.
    hold_reset();
    prog[0] = i_ins(6'b001000, 0, 8, 5);
    prog[1] = i_ins(6'b001000, 8, 9, 3);
    load_prog(2);
    dut.rf[8] = 32'hDEAD;
    dut.rf[9] = 32'hDEAD;
    go();
    tick(4);
    chk("fwd_r8_before_latency", dut.rf[8], 32'hDEAD);
    tick(1);
    chk("fwd_r8_cycle5", dut.rf[8], 32'd5);
    tick(1);
    chk("fwd_r9_cycle6", dut.rf[9], 32'd8);
    $display("scenario forward done");

    // Scenario: load-use costs exactly one stall cycle.
    hold_reset();
    prog[0] = i_ins(6'b100011, 0, 8, 0);
    prog[1] = r_ins(6'b100000, 8, 8, 9);
    load_prog(2);
    dut.dmem[0] = 8'd5; dut.dmem[1] = 8'd0; dut.dmem[2] = 8'd0; dut.dmem[3] = 8'd0;
    dut.rf[9] = 32'd0;
    go();
    tick(1); chk("lu_pc1", dut.pc_reg, 32'd4);
    tick(1); chk("lu_pc2", dut.pc_reg, 32'd8);
    tick(1); chk("lu_pc3_stall", dut.pc_reg, 32'd8);
    tick(1); chk("lu_pc4", dut.pc_reg, 32'd12);
    tick(10);
    chk("lu_r8", dut.rf[8], 32'd5);
    chk("lu_r9", dut.rf[9], 32'd10);
    $display("scenario load-use done");

    // Scenario: taken beq flushes the next fetch.
    hold_reset();
    prog[0] = i_ins(6'b000100, 0, 0, 1);
    prog[1] = i_ins(6'b001000, 0, 10, 7);
    prog[2] = i_ins(6'b001000, 0, 11, 9);
    load_prog(3);
    dut.rf[10] = 32'd0;
    dut.rf[11] = 32'd0;
    go();
    tick(1); chk("beq_pc1", dut.pc_reg, 32'd4);
    tick(1); chk("beq_pc2", dut.pc_reg, 32'd8);
    tick(1); chk("beq_pc3", dut.pc_reg, 32'd12);
    tick(10);
    chk("beq_r10", dut.rf[10], 32'd0);
    chk("beq_r11", dut.rf[11], 32'd9);
    $display("scenario beq done");

    // Scenario: jump to word 4 skips the instruction at word 1.
    hold_reset();
    prog[0] = j_ins(4);
    prog[1] = i_ins(6'b001000, 0, 12, 1);
    prog[2] = 32'd0;
    prog[3] = 32'd0;
    prog[4] = i_ins(6'b001000, 0, 13, 2);
    load_prog(5);
    dut.rf[12] = 32'h55;
    dut.rf[13] = 32'd0;
    go();
    chk("j_pc0", dut.pc_reg, 32'd0);
    tick(1); chk("j_pc1", dut.pc_reg, 32'd4);
    tick(1); chk("j_pc2", dut.pc_reg, 32'd16);
    tick(1); chk("j_pc3", dut.pc_reg, 32'd20);
    tick(10);
    chk("j_r12", dut.rf[12], 32'h55);
    chk("j_r13", dut.rf[13], 32'd2);
    $display("scenario jump done");

    // Scenario: negative store, load back, multiply by a negative.
    hold_reset();
    prog[0] = i_ins(6'b001000, 0, 8, -2);
    prog[1] = i_ins(6'b101011, 0, 8, 4);
    prog[2] = i_ins(6'b100011, 0, 13, 4);
    prog[3] = i_ins(6'b001000, 0, 14, 3);
    prog[4] = r_ins(6'b011000, 14, 8, 15);
    load_prog(5);
    for (int i = 0; i < 32; i++) dut.dmem[i] = 8'd0;
    go();
    tick(15);
    chk("sw_byte4", 32'(dut.dmem[4]), 32'hFE);
    chk("sw_byte5", 32'(dut.dmem[5]), 32'hFF);
    chk("sw_byte6", 32'(dut.dmem[6]), 32'hFF);
    chk("sw_byte7", 32'(dut.dmem[7]), 32'hFF);
    chk("lw_r13", dut.rf[13], 32'hFFFF_FFFE);
    chk("mul_r15", dut.rf[15], 32'hFFFF_FFFA);
    $display("scenario store/mul done");

    // Scenario: start low holds PC; reset mid-program discards in-flight work.
    hold_reset();
    for (int i = 0; i < 8; i++) prog[i] = i_ins(6'b001000, 0, 16 + i, 116 + i);
    load_prog(8);
    for (int r = 16; r < 24; r++) dut.rf[r] = 32'd0;
    rst = 1'b0;
    start = 1'b0;
    chk("rst_ifid_zero", dut.ifid_instr_reg, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick(1);
      chk($sformatf("idle_pc%0d", c), dut.pc_reg, 32'd0);
    end
    start = 1'b1;
    tick(6);
    chk("mid_r16", dut.rf[16], 32'd116);
    chk("mid_r17", dut.rf[17], 32'd117);
    rst = 1'b1;
    tick(3);
    chk("mid_rst_pc", dut.pc_reg, 32'd0);
    chk("mid_rst_ifid", dut.ifid_instr_reg, 32'd0);
    chk("mid_rst_exmem_ctrl", 32'(dut.exmem_ctrl_reg), 32'd0);
    for (int r = 19; r < 24; r++) chk($sformatf("mid_rst_r%0d", r), dut.rf[r], 32'd0);
    rst = 1'b0;
    tick(1);
    chk("resume_pc", dut.pc_reg, 32'd4);
    tick(14);
    chk("resume_r23", dut.rf[23], 32'd123);
    $display("scenario start/reset done");

    // Random programs against the interpreter.
    for (int p = 0; p < 6; p++) begin
      int n;
      n = 24;
      hold_reset();
      gen_prog(n);
      load_prog(n);
      for (int r = 0; r < 32; r++) begin
        logic [31:0] v;
        v = (r % 2 == 1 || r == 0) ? $urandom : $urandom_range(0, 3);
        dut.rf[r] = v;
        m_rf[r] = (r == 0) ? 32'd0 : v;
      end
      for (int i = 0; i < 32; i++) begin
        logic [7:0] bv;
        bv = 8'($urandom);
        dut.dmem[i] = bv;
        m_dm[i] = bv;
      end
      run_model(n);
      go();
      tick(4 * n + 10);
      for (int r = 1; r < 32; r++)
        chk($sformatf("rand%0d_r%0d", p, r), dut.rf[r], m_rf[r]);
      for (int w = 0; w < 8; w++)
        chk($sformatf("rand%0d_dm%0d", p, w),
            {dut.dmem[4*w+3], dut.dmem[4*w+2], dut.dmem[4*w+1], dut.dmem[4*w]},
            {m_dm[4*w+3], m_dm[4*w+2], m_dm[4*w+1], m_dm[4*w]});
      $display("random program %0d done", p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_cpu.md
PIPELINED_CPU -- requirements
Module: pipelined_cpu

Interface
REQ-001 The block SHALL have no parameters; all sizes below are fixed.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 start_i  input  1  run enable; when 0, the PC holds its value.
REQ-005 The block SHALL contain these internal arrays, which the bench preloads hierarchically:
- instruction memory: 256 x 32-bit words, read at index pc[9:2];
- data memory: 32 x 8-bit bytes, byte-addressed, words little-endian (word at address a = {mem[a+3], mem[a+2], mem[a+1], mem[a]});
- register file: 32 x 32-bit registers.

Function
REQ-006 The block SHALL be a classic five-stage pipeline: IF, ID, EX, MEM, WB, with pipeline registers IF/ID, ID/EX, EX/MEM, MEM/WB.
REQ-007 The block SHALL implement these MIPS-encoded instructions:
- R-type, opcode 000000: add (funct 100000), sub (100010), and (100100), or (100101), mul (011000, low 32 bits of the product);
- addi (opcode 001000), lw (100011), sw (101011), beq (000100), j (000010).
REQ-008 Unknown opcodes or funct codes SHALL execute as a NOP: no register write and no memory write.
REQ-009 Immediates SHALL be sign-extended to 32 bits, and all arithmetic SHALL wrap modulo 2^32.
REQ-010 Register $0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-011 The register file SHALL be written in WB, and a same-cycle ID read of the written register SHALL return the new value (write-before-read bypass).
REQ-012 Sequential fetch: PC advances by 4 each cycle while start_i=1 and no stall is active.
REQ-013 beq SHALL resolve in ID:
- compare uses forwarded operands;
- if taken, PC <= PC_ID+4+(sext(imm)<<2);
- if taken, the IF/ID register SHALL be flushed to 0 (one-cycle penalty).
REQ-014 j SHALL resolve in ID: PC <= {PC_ID+4[31:28], target26, 2'b00}, and IF/ID SHALL be flushed.
REQ-015 Forwarding unit: for EX operands, EX/MEM forwarding SHALL have priority over MEM/WB forwarding.
REQ-016 A forward SHALL fire only when the source stage has RegWrite=1, its destination is nonzero, and its destination equals the operand's register.
REQ-017 Load-use hazard: when ID/EX holds an lw whose rt equals the ID-stage rs or rt, the block SHALL stall exactly one cycle:
- PC and IF/ID hold;
- a bubble (all control signals 0) is inserted into ID/EX.
REQ-018 A beq that depends on an instruction still in EX, or on an lw in EX or MEM, SHALL stall until its operands can be forwarded to ID.
REQ-019 If a stall and a flush occur in the same cycle, the stall SHALL take precedence, and the flush SHALL apply once the stall clears.
REQ-020 sw SHALL write 4 bytes in MEM; lw SHALL read 4 bytes in MEM. Addresses are word-aligned (a[1:0] ignored), and data memory addresses wrap modulo 32.
REQ-021 PC wraps modulo 1024 bytes for instruction fetch.
REQ-022 Latency: a result is architecturally visible in the register file at the end of cycle 5 after its fetch, absent stalls.

Reset
REQ-023 On rst_i=1 at a clock edge, the block SHALL set:
- PC to 0;
- every field of every pipeline register, including all control bits, to 0;
- the hazard unit outputs to their non-stall values.
REQ-024 Reset SHALL NOT clear the instruction memory, data memory or register file.
REQ-025 Reset mid-operation SHALL discard all in-flight instructions; no memory or register write occurs from them after the reset edge.
REQ-026 Reset SHALL take priority over start_i, stalls and flushes.
REQ-027 After reset is released with start_i=1, fetch SHALL resume at address 0.

Verification
REQ-028 Scenario: addi $8,$0,5; addi $9,$8,3 back-to-back -> $8=5, $9=8, via EX/MEM forwarding with no stall.
REQ-029 Scenario: data mem[0]=5; lw $8,0($0); add $9,$8,$8 -> exactly one stall cycle, $9=10.
REQ-030 Scenario: beq $0,$0,+1 followed by addi $10,$0,7 and addi $11,$0,9 -> one flush, $10=0, $11=9.
REQ-031 Scenario: j to word 4 with addi $12,$0,1 at word 1 -> $12 unchanged, PC sequence 0, 4, 16.
REQ-032 Scenario: addi $8,$0,-2; sw $8,4($0) -> data bytes 4..7 = FE FF FF FF, word 0x04 reads 4294967294; mul of 3 by -2 gives -6.
REQ-033 Scenario: start_i=0 for 3 cycles -> PC stays 0; assert rst_i mid-program -> PC=0 and no further writes from in-flight instructions.
